counter_seq_ctrl: RTL and testbench

AXI4-Lite master controller that runs a complete measurement run on the counter peripheral. It sits between a simple start/done control interface and the peripheral's AXI4-Lite slave port. On each `start` it programs INIT_VAL, enables the counter, polls COUNT until it reaches a threshold or a poll limit, disables the counter, and reports the final count with a status flag. Only one bus transaction is ever outstanding.

---
 rtl/counter_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// AXI4-Lite master that runs one measurement run on the counter peripheral:
// program INIT_VAL, enable, poll COUNT until threshold or poll limit, then disable.
module counter_seq_ctrl #(
  parameter logic [31:0] ADDR_CTRL  = 32'h00,
  parameter logic [31:0] ADDR_COUNT = 32'h04,
  parameter logic [31:0] ADDR_INIT  = 32'h08,
  parameter int unsigned POLL_GAP   = 4,
  parameter logic [31:0] POLL_MAX   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] init_val,
  input  logic [31:0] threshold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] final_count,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  typedef enum logic [2:0] {IDLE, WR_INIT, WR_EN, RD_CNT, GAP, WR_DIS, DONE} state_t;

  state_t      state, state_next;
  logic        aw_done, w_done, ar_done;
  logic [31:0] init_reg, thr_reg, read_cnt, read_cnt_inc;
  logic [7:0]  gap_cnt;
  logic        err_set, is_wr, b_hs, r_hs;

  always_comb begin
    is_wr        = (state == WR_INIT) || (state == WR_EN) || (state == WR_DIS);
    busy         = (state != IDLE) && (state != DONE);
    done         = (state == DONE);
    awvalid      = is_wr && !aw_done;
    wvalid       = is_wr && !w_done;
    bready       = is_wr;
    wstrb        = 4'hF;
    arvalid      = (state == RD_CNT) && !ar_done;
    rready       = (state == RD_CNT);
    araddr       = (state == RD_CNT) ? ADDR_COUNT : 32'h0;
    b_hs         = bvalid && bready;
    r_hs         = rvalid && rready;
    read_cnt_inc = (read_cnt == 32'hFFFF_FFFF) ? read_cnt : read_cnt + 32'd1;
    awaddr       = 32'h0;
    wdata        = 32'h0;
    case (state)
      WR_INIT: begin awaddr = ADDR_INIT; wdata = init_reg; end
      WR_EN:   begin awaddr = ADDR_CTRL; wdata = 32'h1;    end
      WR_DIS:  begin awaddr = ADDR_CTRL; wdata = 32'h0;    end
      default: ;
    endcase
  end

  // Any error response before the disable still routes through WR_DIS so the counter is stopped.
  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    case (state)
      IDLE:    if (start) state_next = WR_INIT;
      WR_INIT: if (b_hs) begin
                 if (bresp != 2'b00) begin err_set = 1'b1; state_next = WR_DIS; end
                 else state_next = WR_EN;
               end
      WR_EN:   if (b_hs) begin
                 if (bresp != 2'b00) begin err_set = 1'b1; state_next = WR_DIS; end
                 else state_next = RD_CNT;
               end
      RD_CNT:  if (r_hs) begin
                 if (rresp != 2'b00) begin
                   err_set    = 1'b1;
                   state_next = WR_DIS;
                 end else if (rdata >= thr_reg) begin
                   state_next = WR_DIS;
                 end else if ((POLL_MAX != 32'd0) && (read_cnt_inc == POLL_MAX)) begin
                   err_set    = 1'b1;
                   state_next = WR_DIS;
                 end else begin
                   state_next = GAP;
                 end
               end
      GAP:     if (gap_cnt == 8'(POLL_GAP)) state_next = RD_CNT;
      WR_DIS:  if (b_hs) begin
                 if (bresp != 2'b00) err_set = 1'b1;
                 state_next = DONE;
               end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-phase handshake flags and the gap counter restart on every state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      ar_done     <= 1'b0;
      gap_cnt     <= 8'd0;
      init_reg    <= 32'h0;
      thr_reg     <= 32'h0;
      read_cnt    <= 32'h0;
      err         <= 1'b0;
      final_count <= 32'h0;
    end else begin
      state <= state_next;
      if (state != state_next) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        ar_done <= 1'b0;
        gap_cnt <= 8'd0;
      end else begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
        if (arvalid && arready) ar_done <= 1'b1;
        if (state == GAP)       gap_cnt <= gap_cnt + 8'd1;
      end
      if (state == IDLE && start) begin
        init_reg    <= init_val;
        thr_reg     <= threshold;
        read_cnt    <= 32'h0;
        err         <= 1'b0;
        final_count <= 32'h0;
      end
      if (state == RD_CNT && r_hs) begin
        final_count <= rdata;
        read_cnt    <= read_cnt_inc;
      end
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench: behavioural AXI-Lite counter peripheral plus a transaction-level
// reference of the run sequence, driven with randomized latencies, thresholds and errors.
module tb_counter_seq_ctrl;

  localparam logic [31:0] ADDR_CTRL  = 32'h00;
  localparam logic [31:0] ADDR_COUNT = 32'h04;
  localparam logic [31:0] ADDR_INIT  = 32'h08;
  localparam int unsigned POLL_GAP   = 4;
  localparam logic [31:0] POLL_MAX   = 32'd8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] init_val = '0, threshold = '0;
  logic busy, done, err;
  logic [31:0] final_count, awaddr, wdata, araddr;
  logic [3:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0] bresp = 0, rresp = 0;
  logic [31:0] rdata = 0;

  counter_seq_ctrl #(.ADDR_CTRL(ADDR_CTRL), .ADDR_COUNT(ADDR_COUNT), .ADDR_INIT(ADDR_INIT),
                     .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_val(init_val), .threshold(threshold),
    .busy(busy), .done(done), .err(err), .final_count(final_count),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp));

  always #5 clk = ~clk;

  typedef struct { bit is_rd; logic [31:0] addr; logic [31:0] data; logic [1:0] resp; } txn_t;
  txn_t txq[$];

  int checks = 0, fails = 0;
  int inject_idx = -1, fixed_aw = -1, tx_idx = 0;
  bit rand_lat = 0;

  task automatic checkOutput(input string tag, input logic [159:0] got, input logic [159:0] expv);
    checks++;
    if (got !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic int lat();
    return rand_lat ? int'($urandom_range(0, 2)) : 0;
  endfunction

  function automatic logic [1:0] respAt(input int p);
    return (p < txq.size()) ? txq[p].resp : 2'b00;
  endfunction

  function automatic logic [31:0] dataAt(input int p);
    return (p < txq.size()) ? txq[p].data : 32'h0;
  endfunction

  // Peripheral model and bus slave: handshakes are sampled at negedge and acted on after posedge.
  logic [31:0] p_count = 0;
  bit p_en = 0;
  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, s_aw_got, s_w_got, s_ar_got, last_r_ok;
    bit prev_awv, prev_awhs, prev_wv, prev_whs, prev_arv, prev_arhs;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rd_val, awaddr_s, wdata_s, araddr_s;
    logic [31:0] prev_awaddr, prev_wdata, prev_araddr;
    int aw_wait, w_wait, b_wait, r_wait, cyc, last_r;
    {s_aw_got, s_w_got, s_ar_got, last_r_ok} = '0;
    {prev_awv, prev_awhs, prev_wv, prev_whs, prev_arv, prev_arhs} = '0;
    {aw_wait, w_wait, b_wait, r_wait, cyc, last_r} = '0;
    {s_awaddr, s_wdata, s_araddr, s_rd_val, prev_awaddr, prev_wdata, prev_araddr} = '0;
    forever begin
      @(negedge clk);
      cyc++;
      aw_hs = awvalid && awready;  w_hs = wvalid && wready;  b_hs = bvalid && bready;
      ar_hs = arvalid && arready;  r_hs = rvalid && rready;
      awaddr_s = awaddr;  wdata_s = wdata;  araddr_s = araddr;
      if (prev_awv && !prev_awhs && awvalid) checkOutput("awaddr_stable", awaddr, prev_awaddr);
      if (prev_wv && !prev_whs && wvalid)    checkOutput("wdata_stable", wdata, prev_wdata);
      if (prev_arv && !prev_arhs && arvalid) checkOutput("araddr_stable", araddr, prev_araddr);
      if (arvalid && !prev_arv && last_r_ok) checkOutput("poll_gap", cyc - last_r, 2 + POLL_GAP);
      if (r_hs) begin last_r = cyc; last_r_ok = 1; end
      if (b_hs) last_r_ok = 0;
      prev_awv = awvalid; prev_awhs = aw_hs; prev_awaddr = awaddr;
      prev_wv = wvalid;   prev_whs = w_hs;   prev_wdata = wdata;
      prev_arv = arvalid; prev_arhs = ar_hs; prev_araddr = araddr;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        {awready, wready, bvalid, arready, rvalid} = '0;
        {s_aw_got, s_w_got, s_ar_got, last_r_ok, p_en} = '0;
        p_count = 0; tx_idx = 0; bresp = 0; rresp = 0;
        continue;
      end
      if (p_en) p_count = p_count + 1;
      if (b_hs) begin
        bvalid = 0;
        txq.push_back('{0, s_awaddr, s_wdata, bresp});
        s_aw_got = 0; s_w_got = 0; tx_idx++;
      end
      if (r_hs) begin
        rvalid = 0;
        txq.push_back('{1, s_araddr, rdata, rresp});
        s_ar_got = 0; tx_idx++;
      end
      if (aw_hs) begin s_aw_got = 1; s_awaddr = awaddr_s; end
      if (w_hs)  begin s_w_got = 1;  s_wdata = wdata_s;   end
      if (ar_hs) begin
        s_ar_got = 1; s_araddr = araddr_s;
        s_rd_val = (araddr_s == ADDR_COUNT) ? p_count : {31'h0, p_en};
      end
      if (awvalid && !s_aw_got) begin
        if (aw_wait > 0) begin aw_wait--; awready = 0; end else awready = 1;
      end else begin awready = 0; aw_wait = (fixed_aw >= 0) ? fixed_aw : lat(); end
      if (wvalid && !s_w_got) begin
        if (w_wait > 0) begin w_wait--; wready = 0; end else wready = 1;
      end else begin wready = 0; w_wait = lat(); end
      if (arvalid && !s_ar_got) begin
        if (r_wait > 0) begin r_wait--; arready = 0; end else arready = 1;
      end else arready = 0;
      if (!bvalid) begin
        if (s_aw_got && s_w_got) begin
          if (b_wait > 0) b_wait--;
          else begin
            bvalid = 1;
            bresp = (tx_idx == inject_idx) ? 2'b10 : 2'b00;
            if (bresp == 2'b00 && s_awaddr == ADDR_INIT) p_count = s_wdata;
            if (bresp == 2'b00 && s_awaddr == ADDR_CTRL) p_en = s_wdata[0];
          end
        end else b_wait = lat();
      end
      if (!rvalid && s_ar_got && !ar_hs) begin
        rvalid = 1; rdata = s_rd_val;
        rresp = (tx_idx == inject_idx) ? 2'b10 : 2'b00;
      end
      if (!arvalid && !s_ar_got) r_wait = lat();
    end
  end

  // Builds the expected run from the sequencing rules and the read data actually returned.
  task automatic modelRun(input logic [31:0] iv, input logic [31:0] thr, output bit err_exp,
                          output bit have_rd, output logic [31:0] last_rd, output int n_rd);
    txn_t expq[$];
    int p;
    err_exp = 0; have_rd = 0; last_rd = 0; n_rd = 0;
    expq.push_back('{0, ADDR_INIT, iv, 2'b00});
    if (respAt(0) != 2'b00) err_exp = 1;
    else begin
      expq.push_back('{0, ADDR_CTRL, 32'h1, 2'b00});
      if (respAt(1) != 2'b00) err_exp = 1;
      else begin
        for (int k = 1; k <= 100000; k++) begin
          p = expq.size();
          last_rd = dataAt(p); have_rd = 1; n_rd = k;
          expq.push_back('{1, ADDR_COUNT, last_rd, 2'b00});
          if (respAt(p) != 2'b00) begin err_exp = 1; break; end
          if (last_rd >= thr) break;
          if (POLL_MAX != 0 && k == int'(POLL_MAX)) begin err_exp = 1; break; end
        end
      end
    end
    p = expq.size();
    expq.push_back('{0, ADDR_CTRL, 32'h0, 2'b00});
    if (respAt(p) != 2'b00) err_exp = 1;
    checkOutput("txn_count", txq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < txq.size(); i++)
      checkOutput($sformatf("txn%0d", i), {txq[i].is_rd, txq[i].addr, txq[i].data},
                  {expq[i].is_rd, expq[i].addr, expq[i].data});
  endtask

  task automatic applyStimulus(input logic [31:0] iv, input logic [31:0] thr, input int inj,
                               input int aw_fix, input bit rl, input bit pulse, output int n_rd);
    bit found, err_exp, have_rd;
    logic [31:0] last_rd;
    int aw_cnt, w_cnt;
    inject_idx = inj; fixed_aw = aw_fix; rand_lat = rl; n_rd = 0;
    @(negedge clk);
    txq.delete(); tx_idx = 0;
    init_val = iv; threshold = thr; start = 1;
    @(posedge clk); #1;
    start = 0; init_val = $urandom; threshold = $urandom;
    checkOutput("start_resp", {busy, awvalid, wvalid, awaddr}, {3'b111, ADDR_INIT});
    if (aw_fix >= 0) begin
      aw_cnt = 0; w_cnt = 0;
      for (int k = 0; k < 20; k++) begin
        if (awvalid) aw_cnt++;
        if (wvalid) w_cnt++;
        if (!awvalid && !wvalid) break;
        @(posedge clk); #1;
      end
      checkOutput("bp_aw_cycles", aw_cnt, aw_fix + 1);
      checkOutput("bp_w_cycles", w_cnt, 1);
    end
    found = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin found = 1; break; end
      start = pulse && (k == 5);
      init_val = $urandom;
    end
    start = 0;
    checkOutput("done_seen", found, 1);
    if (found) begin
      checkOutput("busy_at_done", busy, 0);
      modelRun(iv, thr, err_exp, have_rd, last_rd, n_rd);
      checkOutput("err", err, err_exp);
      if (have_rd) checkOutput("final_count", final_count, last_rd);
      if (inj < 0) checkOutput("periph_disabled", p_en, 0);
      @(negedge clk);
      checkOutput("done_pulse", {done, busy}, 2'b00);
      checkOutput("err_held", err, err_exp);
    end
  endtask

  initial begin
    int n_rd;
    bit found;
    logic [31:0] iv, thr;
    logic [159:0] rst_vec;
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_vec = 160'({busy, done, err, awvalid, wvalid, bready, arvalid, rready,
                    final_count, awaddr, wdata, araddr, wstrb});
    checkOutput("reset_state", rst_vec, 160'({8'h0, 128'h0, 4'hF}));
    rst_n = 1;

    $display("[TB] normal run");
    applyStimulus(32'h1000, 32'h1010, -1, -1, 0, 0, n_rd);
    checkOutput("normal_final_ge", final_count >= 32'h1010, 1);
    checkOutput("normal_err", err, 0);

    $display("[TB] immediate hit");
    applyStimulus(32'h1000, 32'h0FFF, -1, -1, 0, 0, n_rd);
    checkOutput("hit_reads", n_rd, 1);
    checkOutput("hit_final_ge", final_count >= 32'h1000, 1);

    $display("[TB] timeout");
    applyStimulus(32'h20, 32'hFFFF_FFFF, -1, -1, 0, 0, n_rd);
    checkOutput("timeout_reads", n_rd, 8);
    checkOutput("timeout_err", err, 1);

    $display("[TB] init write error");
    applyStimulus(32'h55, 32'h60, 0, -1, 0, 0, n_rd);
    checkOutput("errresp_reads", n_rd, 0);
    checkOutput("errresp_txns", txq.size(), 2);
    checkOutput("errresp_err", err, 1);

    $display("[TB] backpressure with start pulse while busy");
    applyStimulus(32'h300, 32'h305, -1, 3, 0, 1, n_rd);

    $display("[TB] reset during GAP");
    inject_idx = -1; fixed_aw = -1; rand_lat = 0;
    @(negedge clk);
    txq.delete(); tx_idx = 0;
    init_val = 32'h10; threshold = 32'hFFFF_FFFF; start = 1;
    found = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (rvalid && rready) begin found = 1; break; end
    end
    start = 0;
    checkOutput("reached_read", found, 1);
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(posedge clk); #1;
    rst_vec = 160'({busy, done, err, awvalid, wvalid, bready, arvalid, rready,
                    final_count, awaddr, wdata, araddr, wstrb});
    checkOutput("midrun_reset", rst_vec, 160'({8'h0, 128'h0, 4'hF}));
    @(negedge clk);
    rst_n = 1;
    applyStimulus(32'h400, 32'h408, -1, -1, 0, 0, n_rd);

    $display("[TB] randomized runs");
    for (int r = 0; r < 12; r++) begin
      iv = ($urandom & 32'h7FFF_FFFF) | 32'h100;
      case ($urandom_range(0, 3))
        0:       thr = iv - $urandom_range(0, 5);
        3:       thr = 32'hFFFF_FFFF;
        default: thr = iv + $urandom_range(1, 40);
      endcase
      applyStimulus(iv, thr, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1,
                    -1, 1, bit'($urandom_range(0, 1)), n_rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
